cr_clint_busif_arb: RTL and testbench
=====================================

Name: cr_clint_busif_arb

Overview:
- Two-requester bus front end for the CLINT register block.
- Arbitrates a CPU port and a debug port onto the single CLINT register interface.
- Decodes the address into register selects and sequences each access through a 3-state FSM.
- Returns read data and error status to the granted requester.
- Sits between the core/debug bus adapters and the CLINT register file; drives its select, write and mode inputs and muxes its value outputs.

Parameters:
- ADDR_W, 16, requester address width (byte offset within the CLINT window).
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clint_clk  in  1  block clock.
- cpurst_b  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held with its fields until cpu_ack.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data.
- cpu_mode  in  2  privilege mode of the requester (2'b11 = M).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag, valid with cpu_ack.
- cpu_rdata  out  32  read data, valid with cpu_ack, else 0.
- dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_mode, dbg_ack, dbg_err, dbg_rdata: same widths and meanings as the cpu_* ports, for the debug requester.
- busif_regs_msip_sel  out  1  MSIP select.
- busif_regs_mtimecmp_lo_sel  out  1  MTIMECMP low-word select.
- busif_regs_mtimecmp_hi_sel  out  1  MTIMECMP high-word select.
- busif_regs_wdata  out  32  write data to the register file.
- busif_regs_write_vld  out  1  write strobe.
- cpu_clint_mode  out  2  mode of the granted requester.
- msip_value, mtimecmp_lo_value, mtimecmp_hi_value, mtime_lo_value, mtime_hi_value  in  32 each  register read values.

Behaviour:
- Clocking and reset: one clock, clint_clk. Reset cpurst_b is asynchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - RR pointer = CPU preferred.
  - All acks, errs, rdata, sels, busif_regs_write_vld and busif_regs_wdata = 0.
  - cpu_clint_mode = 2'b00.
- Address map (byte offset):
  - 0x0000 MSIP, read/write.
  - 0x4000 MTIMECMP_LO, read/write.
  - 0x4004 MTIMECMP_HI, read/write.
  - 0xBFF8 MTIME_LO, read-only.
  - 0xBFFC MTIME_HI, read-only.
- FSM IDLE -> ACCESS -> RESP -> IDLE. One access is in flight at a time.
- IDLE:
  - If any req is high, grant one requester.
  - Latch that requester's write, addr, wdata and mode, then go to ACCESS.
  - If both reqs are high, grant the port not granted last. The RR pointer updates on each grant.
- ACCESS (exactly one cycle):
  - Decode the latched address and drive exactly one sel (or none on error).
  - busif_regs_wdata = latched wdata. cpu_clint_mode = latched mode.
  - busif_regs_write_vld = write & ~err.
  - For reads, capture the value mux into the rdata register.
- err is set for any of:
  - addr[1:0] != 0;
  - address not in the map;
  - write to MTIME_LO or MTIME_HI;
  - write with mode != 2'b11.
- Reads are permitted in any mode. On err, no sel is asserted, no write occurs, and rdata = 0.
- RESP: pulse the granted port's ack for 1 cycle with err and rdata, then return to IDLE.
- Latency: req seen in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2. Minimum spacing between back-to-back grants is 3 cycles.
- Write data: register contents update at the end of the ACCESS cycle. A read issued after a write returns the new value.
- The non-granted port sees no ack. Its req stays pending and is served next.
- Dropping req before ack is illegal; behaviour is undefined.
- Reset mid-access: FSM returns to IDLE and no ack is generated. The requester must reissue.

Optional Feature:
- Macro: CLINT_DBG_PORT_EN.
- Defined: debug port active as described above.
- Undefined:
  - dbg_* inputs are ignored.
  - dbg_ack, dbg_err and dbg_rdata are tied to 0.
  - The arbiter degenerates to CPU-only; the RR pointer is removed.
  - Latency is unchanged.

Test Plan:
- CPU write 0x4000 = 0xDEADBEEF, mode 2'b11 -> mtimecmp_lo_sel and write_vld high in cycle N+1; cpu_ack at N+2 with err=0; a subsequent read of 0x4000 returns 0xDEADBEEF.
- CPU write 0x0000 = 0x1 with mode 2'b00 -> no write_vld; cpu_ack with cpu_err=1; MSIP read returns 0.
- CPU and dbg req in the same cycle after reset, both reading 0xBFF8 with mtime_lo_value = 0x12345678 -> CPU acked at N+2; dbg acked at N+5; both return 0x12345678.
- Bad accesses each give ack with err=1, no sel asserted, rdata = 0:
  - read 0x4002 (misaligned);
  - read 0x1000 (unmapped);
  - write 0xBFFC (read-only).
- Reset asserted during ACCESS of a write -> no ack; FSM idle after release; a new request completes normally at N+2.
- Build with CLINT_DBG_PORT_EN undefined, dbg_req held high -> dbg_ack never asserts; CPU accesses unaffected.

Source files
------------

// File: rtl/cr_clint_busif_arb_if.sv
// Bus bundle between the CPU/debug requesters, the CLINT arbiter and the CLINT register file.
// The arbiter connects through the slave modport; requesters and register file use master.
interface cr_clint_busif_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_mode;
  logic              cpu_ack;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [1:0]        dbg_mode;
  logic              dbg_ack;
  logic              dbg_err;
  logic [DATA_W-1:0] dbg_rdata;

  logic              busif_regs_msip_sel;
  logic              busif_regs_mtimecmp_lo_sel;
  logic              busif_regs_mtimecmp_hi_sel;
  logic [DATA_W-1:0] busif_regs_wdata;
  logic              busif_regs_write_vld;
  logic [1:0]        cpu_clint_mode;

  logic [DATA_W-1:0] msip_value;
  logic [DATA_W-1:0] mtimecmp_lo_value;
  logic [DATA_W-1:0] mtimecmp_hi_value;
  logic [DATA_W-1:0] mtime_lo_value;
  logic [DATA_W-1:0] mtime_hi_value;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_mode,
    output cpu_ack, cpu_err, cpu_rdata,
    input  dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_mode,
    output dbg_ack, dbg_err, dbg_rdata,
    output busif_regs_msip_sel, busif_regs_mtimecmp_lo_sel, busif_regs_mtimecmp_hi_sel,
    output busif_regs_wdata, busif_regs_write_vld, cpu_clint_mode,
    input  msip_value, mtimecmp_lo_value, mtimecmp_hi_value, mtime_lo_value, mtime_hi_value
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, cpu_mode,
    input  cpu_ack, cpu_err, cpu_rdata,
    output dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_mode,
    input  dbg_ack, dbg_err, dbg_rdata,
    input  busif_regs_msip_sel, busif_regs_mtimecmp_lo_sel, busif_regs_mtimecmp_hi_sel,
    input  busif_regs_wdata, busif_regs_write_vld, cpu_clint_mode,
    output msip_value, mtimecmp_lo_value, mtimecmp_hi_value, mtime_lo_value, mtime_hi_value
  );
endinterface

// File: rtl/cr_clint_busif_arb.sv
// CLINT bus front end: round-robin CPU/debug arbiter, address decode, IDLE->ACCESS->RESP sequencer.
// Optional debug requester enabled by defining CLINT_DBG_PORT_EN; otherwise CPU-only.
module cr_clint_busif_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                 clint_clk,
  input  logic                 cpurst_b,
  cr_clint_busif_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] A_MSIP    = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] A_MTCMPLO = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] A_MTCMPHI = ADDR_W'(16'h4004);
  localparam logic [ADDR_W-1:0] A_MTIMELO = ADDR_W'(16'hBFF8);
  localparam logic [ADDR_W-1:0] A_MTIMEHI = ADDR_W'(16'hBFFC);

  state_t              state_q, state_d;
  logic                gnt_dbg_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          mode_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_req, grant_dbg;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [1:0]          req_mode;
  logic                start;

`ifdef CLINT_DBG_PORT_EN
  logic rr_q;  // 1: debug preferred on a tie (CPU was granted last)

  assign any_req   = bus.cpu_req | bus.dbg_req;
  assign grant_dbg = bus.dbg_req & (~bus.cpu_req | rr_q);
  assign req_write = grant_dbg ? bus.dbg_write : bus.cpu_write;
  assign req_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign req_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  assign req_mode  = grant_dbg ? bus.dbg_mode  : bus.cpu_mode;

  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b)  rr_q <= 1'b0;
    else if (start) rr_q <= ~grant_dbg;
  end
`else
  logic unused_dbg;

  assign any_req    = bus.cpu_req;
  assign grant_dbg  = 1'b0;
  assign req_write  = bus.cpu_write;
  assign req_addr   = bus.cpu_addr;
  assign req_wdata  = bus.cpu_wdata;
  assign req_mode   = bus.cpu_mode;
  assign unused_dbg = ^{bus.dbg_req, bus.dbg_write, bus.dbg_addr, bus.dbg_wdata, bus.dbg_mode};
`endif

  assign start = (state_q == IDLE) & any_req;

  // Decode of the latched address; only meaningful while in ACCESS.
  logic              hit_msip, hit_lo, hit_hi, hit_mtlo, hit_mthi, acc_err;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    hit_msip = (addr_q == A_MSIP);
    hit_lo   = (addr_q == A_MTCMPLO);
    hit_hi   = (addr_q == A_MTCMPHI);
    hit_mtlo = (addr_q == A_MTIMELO);
    hit_mthi = (addr_q == A_MTIMEHI);
    acc_err  = (addr_q[1:0] != 2'b00)
             | ~(hit_msip | hit_lo | hit_hi | hit_mtlo | hit_mthi)
             | (write_q & (hit_mtlo | hit_mthi))
             | (write_q & (mode_q != 2'b11));
    rd_mux = '0;
    if (hit_msip) rd_mux = bus.msip_value;
    if (hit_lo)   rd_mux = bus.mtimecmp_lo_value;
    if (hit_hi)   rd_mux = bus.mtimecmp_hi_value;
    if (hit_mtlo) rd_mux = bus.mtime_lo_value;
    if (hit_mthi) rd_mux = bus.mtime_hi_value;
  end

  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= IDLE;
    else           state_q <= state_d;
  end

  logic in_access, resp_ack;
  logic sel_msip, sel_lo, sel_hi, write_vld;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    in_access = 1'b0;
    resp_ack  = 1'b0;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  begin in_access = 1'b1; state_d = RESP; end
      RESP:    begin resp_ack  = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    sel_msip  = in_access & hit_msip & ~acc_err;
    sel_lo    = in_access & hit_lo   & ~acc_err;
    sel_hi    = in_access & hit_hi   & ~acc_err;
    write_vld = in_access & write_q  & ~acc_err;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      gnt_dbg_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else if (start) begin
      gnt_dbg_q <= grant_dbg;
      write_q   <= req_write;
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
      mode_q    <= req_mode;
    end else if (in_access) begin
      err_q   <= acc_err;
      rdata_q <= (~write_q & ~acc_err) ? rd_mux : '0;
    end
  end

  assign bus.busif_regs_msip_sel        = sel_msip;
  assign bus.busif_regs_mtimecmp_lo_sel = sel_lo;
  assign bus.busif_regs_mtimecmp_hi_sel = sel_hi;
  assign bus.busif_regs_write_vld       = write_vld;
  assign bus.busif_regs_wdata           = in_access ? wdata_q : '0;
  assign bus.cpu_clint_mode             = in_access ? mode_q  : 2'b00;

  assign bus.cpu_ack   = resp_ack & ~gnt_dbg_q;
  assign bus.cpu_err   = bus.cpu_ack & err_q;
  assign bus.cpu_rdata = bus.cpu_ack ? rdata_q : '0;

`ifdef CLINT_DBG_PORT_EN
  assign bus.dbg_ack   = resp_ack & gnt_dbg_q;
  assign bus.dbg_err   = bus.dbg_ack & err_q;
  assign bus.dbg_rdata = bus.dbg_ack ? rdata_q : '0;
`else
  assign bus.dbg_ack   = 1'b0;
  assign bus.dbg_err   = 1'b0;
  assign bus.dbg_rdata = '0;
`endif

endmodule

// File: tb/tb_cr_clint_busif_arb.sv
// Self-checking bench for cr_clint_busif_arb: scoreboarded responses plus per-access decode checks.
// Works for both builds; debug-port expectations follow CLINT_DBG_PORT_EN.
module tb_cr_clint_busif_arb;

  localparam logic [31:0] MTIME_LO = 32'h1234_5678;
  localparam logic [31:0] MTIME_HI = 32'hCAFE_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_clint_busif_arb_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  cr_clint_busif_arb #(.ADDR_W(16), .DATA_W(32)) dut (
    .clint_clk (clk),
    .cpurst_b  (rst_n),
    .bus       (bus)
  );

  // Register file stand-in: written by the DUT's selects, never reset.
  logic [31:0] rf_msip = '0, rf_lo = '0, rf_hi = '0;
  always @(posedge clk) begin
    if (bus.busif_regs_write_vld) begin
      if (bus.busif_regs_msip_sel)        rf_msip <= bus.busif_regs_wdata;
      if (bus.busif_regs_mtimecmp_lo_sel) rf_lo   <= bus.busif_regs_wdata;
      if (bus.busif_regs_mtimecmp_hi_sel) rf_hi   <= bus.busif_regs_wdata;
    end
  end
  assign bus.msip_value        = rf_msip;
  assign bus.mtimecmp_lo_value = rf_lo;
  assign bus.mtimecmp_hi_value = rf_hi;
  assign bus.mtime_lo_value    = MTIME_LO;
  assign bus.mtime_hi_value    = MTIME_HI;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          dbg;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Reference view of the register contents, updated when a legal write is issued.
  logic [31:0] mdl_msip = '0, mdl_lo = '0, mdl_hi = '0;

  task automatic model(input bit wr, input logic [15:0] addr, input logic [1:0] mode,
                       output bit err, output logic [31:0] rdata, output logic [2:0] sel);
    bit mapped, ro;
    logic [31:0] val;
    mapped = 1'b1; ro = 1'b0; val = '0; sel = 3'b000;
    case (addr)
      16'h0000: begin sel = 3'b100; val = mdl_msip; end
      16'h4000: begin sel = 3'b010; val = mdl_lo;   end
      16'h4004: begin sel = 3'b001; val = mdl_hi;   end
      16'hBFF8: begin ro = 1'b1;    val = MTIME_LO; end
      16'hBFFC: begin ro = 1'b1;    val = MTIME_HI; end
      default:  mapped = 1'b0;
    endcase
    err   = (addr[1:0] != 2'b00) || !mapped || (wr && ro) || (wr && mode != 2'b11);
    rdata = (!wr && !err) ? val : 32'h0;
    if (err) sel = 3'b000;
  endtask

  // Response monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (bus.cpu_ack || bus.dbg_ack)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {31'd0, bus.dbg_ack}, {31'd0, e.dbg});
        if (bus.dbg_ack) begin
          check("dbg_err",   {31'd0, bus.dbg_err}, {31'd0, e.err});
          check("dbg_rdata", bus.dbg_rdata, e.rdata);
          check("cpu_rdata_idle", bus.cpu_rdata, 32'h0);
        end else begin
          check("cpu_err",   {31'd0, bus.cpu_err}, {31'd0, e.err});
          check("cpu_rdata", bus.cpu_rdata, e.rdata);
          check("dbg_rdata_idle", bus.dbg_rdata, 32'h0);
        end
      end
    end
  end

  task automatic drive(input bit dbg, input bit req, input bit wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [1:0] mode);
    if (dbg) begin
      bus.dbg_req = req; bus.dbg_write = wr; bus.dbg_addr = addr;
      bus.dbg_wdata = wdata; bus.dbg_mode = mode;
    end else begin
      bus.cpu_req = req; bus.cpu_write = wr; bus.cpu_addr = addr;
      bus.cpu_wdata = wdata; bus.cpu_mode = mode;
    end
  endtask

  // One complete access on a single port, checking decode outputs in ACCESS and ack latency.
  task automatic access(input bit dbg, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [1:0] mode);
    bit err;
    logic [31:0] rdata;
    logic [2:0] sel;
    exp_t e;
    model(wr, addr, mode, err, rdata, sel);
    e.dbg = dbg; e.err = err; e.rdata = rdata;
    sb.push_back(e);
    if (wr && !err) begin
      if (sel[2]) mdl_msip = wdata;
      if (sel[1]) mdl_lo   = wdata;
      if (sel[0]) mdl_hi   = wdata;
    end
    @(posedge clk); #1;
    drive(dbg, 1'b1, wr, addr, wdata, mode);
    @(negedge clk);
    @(negedge clk);
    check("sel", {29'd0, bus.busif_regs_msip_sel, bus.busif_regs_mtimecmp_lo_sel,
                  bus.busif_regs_mtimecmp_hi_sel}, {29'd0, sel});
    check("write_vld", {31'd0, bus.busif_regs_write_vld}, {31'd0, wr && !err});
    check("clint_mode", {30'd0, bus.cpu_clint_mode}, {30'd0, mode});
    if (wr && !err) check("regs_wdata", bus.busif_regs_wdata, wdata);
    @(negedge clk);
    check("ack_latency", {31'd0, dbg ? bus.dbg_ack : bus.cpu_ack}, 32'd1);
    @(posedge clk); #1;
    drive(dbg, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpu_at, dbg_at;
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00);
    repeat (3) @(negedge clk);
    check("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_dbg_ack", {31'd0, bus.dbg_ack}, 32'd0);
    check("rst_rdata", bus.cpu_rdata | bus.dbg_rdata, 32'h0);
    check("rst_sels", {29'd0, bus.busif_regs_msip_sel, bus.busif_regs_mtimecmp_lo_sel,
                       bus.busif_regs_mtimecmp_hi_sel}, 32'd0);
    check("rst_write_vld", {31'd0, bus.busif_regs_write_vld}, 32'd0);
    check("rst_wdata", bus.busif_regs_wdata, 32'h0);
    check("rst_mode", {30'd0, bus.cpu_clint_mode}, 32'd0);
    rst_n = 1'b1;

    // Simultaneous reads of MTIME_LO from both ports right after reset.
    e.dbg = 1'b0; e.err = 1'b0; e.rdata = MTIME_LO; sb.push_back(e);
`ifdef CLINT_DBG_PORT_EN
    e.dbg = 1'b1; sb.push_back(e);
`endif
    cpu_at = 0; dbg_at = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'hBFF8, 32'h0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 16'hBFF8, 32'h0, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.cpu_ack && cpu_at == 0) cpu_at = k;
      if (bus.dbg_ack && dbg_at == 0) dbg_at = k;
      @(posedge clk); #1;
      if (cpu_at != 0) bus.cpu_req = 1'b0;
`ifdef CLINT_DBG_PORT_EN
      if (dbg_at != 0) bus.dbg_req = 1'b0;
`endif
    end
    check("arb_cpu_ack_cycle", cpu_at, 3);
`ifdef CLINT_DBG_PORT_EN
    check("arb_dbg_ack_cycle", dbg_at, 6);
`else
    check("arb_dbg_never_acked", dbg_at, 0);
    // Debug port keeps asserting a legal M-mode MSIP write; it must have no effect.
    drive(1'b1, 1'b1, 1'b1, 16'h0000, 32'h0000_00FF, 2'b11);
`endif

    access(1'b0, 1'b1, 16'h4000, 32'hDEAD_BEEF, 2'b11);
    access(1'b0, 1'b0, 16'h4000, 32'h0, 2'b11);
    access(1'b0, 1'b1, 16'h0000, 32'h0000_0001, 2'b00);
    access(1'b0, 1'b0, 16'h0000, 32'h0, 2'b11);
    access(1'b0, 1'b0, 16'h4002, 32'h0, 2'b11);
    access(1'b0, 1'b0, 16'h1000, 32'h0, 2'b11);
    access(1'b0, 1'b1, 16'hBFFC, 32'h5555_AAAA, 2'b11);
    access(1'b0, 1'b1, 16'h4004, 32'hA5A5_0001, 2'b11);
    access(1'b0, 1'b0, 16'h4004, 32'h0, 2'b01);
    access(1'b0, 1'b0, 16'hBFFC, 32'h0, 2'b00);
    access(1'b0, 1'b1, 16'h0000, 32'h0000_0001, 2'b11);
    access(1'b0, 1'b0, 16'h0000, 32'h0, 2'b00);
`ifdef CLINT_DBG_PORT_EN
    access(1'b1, 1'b1, 16'h4000, 32'h1122_3344, 2'b11);
    access(1'b1, 1'b0, 16'h4000, 32'h0, 2'b11);
    access(1'b0, 1'b0, 16'h4000, 32'h0, 2'b11);
`endif

    // Reset lands in the ACCESS cycle of a write: the write and its ack must vanish.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 32'h0000_0005, 2'b11);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_write_vld", {31'd0, bus.busif_regs_write_vld}, 32'd1);
    #1 rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_no_ack", {31'd0, bus.cpu_ack}, 32'd0);
    end
    rst_n = 1'b1;
    access(1'b0, 1'b0, 16'h0000, 32'h0, 2'b11);
    check("msip_after_reset", rf_msip, mdl_msip);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
